// File: rtl/prbs31_checker.sv
// PRBS31 (x^31 + x^28 + 1) receive checker and bit-error-rate monitor.
// Self-synchronises to an incoming byte-wide PRBS31 stream, verifies the
// lock over LOCK_BYTES clean bytes, then counts bit errors against a
// free-running local copy of the sequence.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   rx_data    received byte, bit 7 earliest in time, bit 0 latest
//   rx_valid   rx_data accepted on this edge (no backpressure)
//   rx_invert  polarity inversion of rx_data (only with PRBS31_CHK_INVERT_EN)
//   err_clr    synchronous clear of err_cnt, wins over a same-edge increment
//   locked     high while in LOCKED
//   state      00 SEED, 01 VERIFY, 10 LOCKED
//   err_cnt    saturating count of bit errors seen while LOCKED
//   err_byte   one-cycle pulse: previous accepted LOCKED byte had errors
//
// Optional feature: define PRBS31_CHK_INVERT_EN to add the rx_invert port.
module prbs31_checker #(
  parameter int unsigned ERR_W        = 16,
  parameter int unsigned LOCK_BYTES   = 8,
  parameter int unsigned UNLOCK_BYTES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
`ifdef PRBS31_CHK_INVERT_EN
  input  logic             rx_invert,
`endif
  input  logic             err_clr,
  output logic             locked,
  output logic [1:0]       state,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_byte
);

  localparam int unsigned HIST_W = 31;
  localparam int unsigned RUN_W  = 8;
  localparam int unsigned SEED_W = 3;
  localparam int unsigned POP_W  = 4;
  localparam int unsigned SUM_W  = ERR_W + POP_W;
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;
  localparam logic [SEED_W-1:0] SEED_FULL = SEED_W'(4);

  typedef enum logic [1:0] {
    ST_SEED   = 2'b00,
    ST_VERIFY = 2'b01,
    ST_LOCKED = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic [HIST_W-1:0]   hist_q, hist_d;
  logic [SEED_W-1:0]   seed_cnt_q, seed_cnt_d;
  logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
  logic                err_byte_q, err_byte_d;
  logic                locked_q, locked_d;

  logic [7:0]          rx_byte;
  logic [7:0]          pred;
  logic [7:0]          diff;
  logic [POP_W-1:0]    pop;
  logic [SUM_W-1:0]    err_sum;
  logic [ERR_W-1:0]    err_sat;

  // Optional polarity correction ahead of all processing.
`ifdef PRBS31_CHK_INVERT_EN
  assign rx_byte = rx_data ^ {8{rx_invert}};
`else
  assign rx_byte = rx_data;
`endif

  // hist_q[0] is the latest stream bit, hist_q[k] the bit k positions
  // earlier. Stream bit j of the next byte (j=0 earliest) needs s[n-31]
  // and s[n-28], i.e. hist[30-j] and hist[27-j]; both already in hist.
  always_comb begin
    pred = '0;
    for (int j = 0; j < 8; j++) begin
      pred[7-j] = hist_q[30-j] ^ hist_q[27-j];
    end
  end

  assign diff = rx_byte ^ pred;

  // Bit-error count of the current byte.
  always_comb begin
    pop = '0;
    for (int i = 0; i < 8; i++) begin
      pop = pop + POP_W'(diff[i]);
    end
  end

  // Saturating accumulate.
  assign err_sum = SUM_W'(err_cnt_q) + SUM_W'(pop);
  assign err_sat = (err_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : err_sum[ERR_W-1:0];

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    seed_cnt_d = seed_cnt_q;
    run_cnt_d  = run_cnt_q;
    err_cnt_d  = err_cnt_q;
    err_byte_d = 1'b0;

    if (rx_valid) begin
      unique case (state_q)
        ST_SEED: begin
          hist_d     = {hist_q[HIST_W-9:0], rx_byte};
          seed_cnt_d = (seed_cnt_q == SEED_FULL) ? SEED_FULL
                                                 : SEED_W'(seed_cnt_q + 1'b1);
          // All-zero history is the LFSR lock-up state; keep seeding.
          if (seed_cnt_d == SEED_FULL && hist_d != '0) begin
            state_d   = ST_VERIFY;
            run_cnt_d = '0;
          end
        end

        ST_VERIFY: begin
          hist_d = {hist_q[HIST_W-9:0], rx_byte};
          if (diff != '0) begin
            state_d    = ST_SEED;
            seed_cnt_d = '0;
          end else begin
            run_cnt_d = RUN_W'(run_cnt_q + 1'b1);
            if (run_cnt_d == RUN_W'(LOCK_BYTES)) begin
              state_d   = ST_LOCKED;
              run_cnt_d = '0;
            end
          end
        end

        ST_LOCKED: begin
          // Local generator free-runs so a line error is counted once.
          hist_d     = {hist_q[HIST_W-9:0], pred};
          err_cnt_d  = err_sat;
          err_byte_d = (diff != '0);
          if (diff != '0) begin
            run_cnt_d = RUN_W'(run_cnt_q + 1'b1);
            if (run_cnt_d == RUN_W'(UNLOCK_BYTES)) begin
              state_d    = ST_SEED;
              seed_cnt_d = '0;
              run_cnt_d  = '0;
            end
          end else begin
            run_cnt_d = '0;
          end
        end

        default: begin
          state_d    = ST_SEED;
          seed_cnt_d = '0;
          run_cnt_d  = '0;
        end
      endcase
    end

    if (err_clr) begin
      err_cnt_d = '0;
    end
  end

  assign locked_d = (state_d == ST_LOCKED);

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_SEED;
      hist_q     <= '0;
      seed_cnt_q <= '0;
      run_cnt_q  <= '0;
      err_cnt_q  <= '0;
      err_byte_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      seed_cnt_q <= seed_cnt_d;
      run_cnt_q  <= run_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_byte_q <= err_byte_d;
      locked_q   <= locked_d;
    end
  end

  assign locked   = locked_q;
  assign state    = state_q;
  assign err_cnt  = err_cnt_q;
  assign err_byte = err_byte_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// Directed bench for prbs31_checker: a default-width instance and an
// ERR_W=4 instance share one stimulus stream.
module tb_prbs31_checker;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        err_clr;
`ifdef PRBS31_CHK_INVERT_EN
  logic        rx_invert;
`endif

  logic        locked,  locked4;
  logic [1:0]  state,   state4;
  logic [15:0] err_cnt;
  logic [3:0]  err_cnt4;
  logic        err_byte, err_byte4;

  int n_total;
  int n_bad;

  logic [30:0] lfsr;
  logic [7:0]  b;

  prbs31_checker dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
`ifdef PRBS31_CHK_INVERT_EN
    .rx_invert(rx_invert),
`endif
    .err_clr  (err_clr),
    .locked   (locked),
    .state    (state),
    .err_cnt  (err_cnt),
    .err_byte (err_byte)
  );

  prbs31_checker #(.ERR_W(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
`ifdef PRBS31_CHK_INVERT_EN
    .rx_invert(rx_invert),
`endif
    .err_clr  (err_clr),
    .locked   (locked4),
    .state    (state4),
    .err_cnt  (err_cnt4),
    .err_byte (err_byte4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bit-serial reference generator, earliest bit lands in byte bit 7.
  task automatic gen_byte(output logic [7:0] ob);
    logic nb;
    for (int i = 0; i < 8; i++) begin
      nb   = lfsr[30] ^ lfsr[27];
      lfsr = {lfsr[29:0], nb};
      ob[7-i] = nb;
    end
  endtask

  // Present one cycle of inputs, return 1 time unit after the edge.
  task automatic drive(input logic [7:0] d, input logic v, input logic clr);
    rx_data  = d;
    rx_valid = v;
    err_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hits;
    int drops;
    int locks;
    n_total  = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    rx_data  = '0;
    rx_valid = 1'b0;
    err_clr  = 1'b0;
`ifdef PRBS31_CHK_INVERT_EN
    rx_invert = 1'b0;
`endif
    lfsr     = 31'h7FFF_FFFF;

    // Reset values
    #2;
    chk("rst_state",    32'(state),    32'd0);
    chk("rst_locked",   32'(locked),   32'd0);
    chk("rst_err_cnt",  32'(err_cnt),  32'd0);
    chk("rst_err_byte", 32'(err_byte), 32'd0);
    #10 rst_n = 1'b1;

    // Clean lock: first three bytes of this seed are 00 00 00, then 0E
    for (int k = 1; k <= 12; k++) begin
      gen_byte(b);
      drive(b, 1'b1, 1'b0);
      if (k == 3)  chk("seed_after_b3",   32'(state),  32'd0);
      if (k == 4)  chk("verify_after_b4", 32'(state),  32'd1);
      if (k == 11) chk("unlocked_b11",    32'(locked), 32'd0);
      if (k == 12) begin
        chk("locked_b12", 32'(locked), 32'd1);
        chk("state_b12",  32'(state),  32'd2);
      end
    end
    hits = 0;
    drops = 0;
    for (int k = 0; k < 988; k++) begin
      gen_byte(b);
      drive(b, 1'b1, 1'b0);
      if (err_byte) hits++;
      if (!locked)  drops++;
    end
    chk("clean_err_byte_hits", 32'(hits),    32'd0);
    chk("clean_lock_drops",    32'(drops),   32'd0);
    chk("clean_err_cnt",       32'(err_cnt), 32'd0);

    // Idle cycles change nothing
    drive(8'h55, 1'b0, 1'b0);
    drive(8'hAA, 1'b0, 1'b0);
    chk("idle_state", 32'(state), 32'd2);

    // Single error: bit 3 flipped
    gen_byte(b);
    drive(b ^ 8'h08, 1'b1, 1'b0);
    chk("single_err_cnt",  32'(err_cnt),  32'd1);
    chk("single_err_byte", 32'(err_byte), 32'd1);
    chk("single_locked",   32'(locked),   32'd1);
    gen_byte(b);
    drive(b, 1'b1, 1'b0);
    chk("single_pulse_end", 32'(err_byte), 32'd0);
    for (int k = 0; k < 20; k++) begin
      gen_byte(b);
      drive(b, 1'b1, 1'b0);
    end
    chk("single_no_more_err", 32'(err_cnt), 32'd1);

    // Clear on an idle cycle
    drive(8'h00, 1'b0, 1'b1);
    chk("clr_idle_err_cnt", 32'(err_cnt), 32'd0);

    // Unlock: four consecutive bytes with bit 0 flipped
    for (int k = 1; k <= 4; k++) begin
      gen_byte(b);
      drive(b ^ 8'h01, 1'b1, 1'b0);
      if (k == 3) chk("unlock_still_locked_b3", 32'(locked), 32'd1);
    end
    chk("unlock_locked",  32'(locked),   32'd0);
    chk("unlock_state",   32'(state),    32'd0);
    chk("unlock_err_cnt", 32'(err_cnt),  32'd4);
    chk("unlock_err_cnt4", 32'(err_cnt4), 32'd4);

    // Relock on the continuing clean stream
    for (int k = 1; k <= 12; k++) begin
      gen_byte(b);
      drive(b, 1'b1, 1'b0);
      if (k == 4)  chk("relock_verify_b4", 32'(state),  32'd1);
      if (k == 11) chk("relock_b11",       32'(locked), 32'd0);
    end
    chk("relock_locked",  32'(locked),  32'd1);
    chk("relock_err_cnt", 32'(err_cnt), 32'd4);

    // Saturation: 10 double-bit errored bytes separated by clean bytes
    drive(8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      gen_byte(b);
      drive(b ^ 8'h81, 1'b1, 1'b0);
      gen_byte(b);
      drive(b, 1'b1, 1'b0);
    end
    chk("sat_err_cnt4", 32'(err_cnt4), 32'd15);
    chk("sat_err_cnt",  32'(err_cnt),  32'd20);
    chk("sat_locked",   32'(locked4),  32'd1);

    // Clear on the same edge as an errored byte
    gen_byte(b);
    drive(b ^ 8'h10, 1'b1, 1'b1);
    chk("clr_errored_cnt",  32'(err_cnt),  32'd0);
    chk("clr_errored_cnt4", 32'(err_cnt4), 32'd0);
    chk("clr_errored_byte", 32'(err_byte), 32'd1);

    // Asynchronous reset mid-stream with nonzero counters
    gen_byte(b);
    drive(b ^ 8'h40, 1'b1, 1'b0);
    chk("pre_rst_err_cnt", 32'(err_cnt), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_state",    32'(state),    32'd0);
    chk("async_rst_locked",   32'(locked),   32'd0);
    chk("async_rst_err_cnt",  32'(err_cnt),  32'd0);
    chk("async_rst_err_byte", 32'(err_byte), 32'd0);
    #3 rst_n = 1'b1;

    // Inverted-polarity stream
    lfsr = 31'h7FFF_FFFF;
`ifdef PRBS31_CHK_INVERT_EN
    rx_invert = 1'b1;
`endif
    locks = 0;
    for (int k = 0; k < 60; k++) begin
      gen_byte(b);
      drive(~b, 1'b1, 1'b0);
      if (locked) locks++;
    end
`ifdef PRBS31_CHK_INVERT_EN
    chk("invert_locked", 32'(locked), 32'd1);
`else
    chk("invert_locked", 32'(locks), 32'd0);
`endif

    // All-zero stream never leaves SEED
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
`ifdef PRBS31_CHK_INVERT_EN
    rx_invert = 1'b0;
`endif
    drops = 0;
    for (int k = 0; k < 200; k++) begin
      drive(8'h00, 1'b1, 1'b0);
      if (state != 2'b00) drops++;
    end
    chk("zero_state_moves", 32'(drops),  32'd0);
    chk("zero_locked",      32'(locked), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/prbs31_checker.md
Name: prbs31_checker

Overview:
- Receive-side counterpart of the team's PRBS31 pattern generator (polynomial x^31 + x^28 + 1).
- Accepts the pattern 8 bits per accepted byte and self-synchronises to it.
- Verifies lock, then counts bit errors against a free-running local copy of the sequence.
- Sits behind the tile pins as a bit-error-rate monitor for a looped-back or externally driven PRBS31 stream.

Parameters:
- ERR_W, 16: width of the saturating bit-error counter.
- LOCK_BYTES, 8: consecutive error-free bytes needed in VERIFY before declaring lock (1..255).
- UNLOCK_BYTES, 4: consecutive errored bytes in LOCKED that force loss of lock (1..255).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received stream byte; bit 7 is the earliest bit in time, bit 0 the latest.
- rx_valid  in  1  rx_data is accepted on this edge; no backpressure.
- err_clr  in  1  synchronous clear of err_cnt.
- locked  out  1  high while in LOCKED.
- state  out  2  00 SEED, 01 VERIFY, 10 LOCKED.
- err_cnt  out  ERR_W  saturating count of bit errors seen in LOCKED.
- err_byte  out  1  one-cycle pulse; the previously accepted LOCKED byte had at least one bit error.

Behaviour:
- Sequence definition: s[n] = s[n-31] XOR s[n-28], with bits numbered in stream order.
- History register hist[30:0] holds the last 31 stream bits.
- Prediction: all 8 predicted bits of a byte depend only on hist, since n+7-28 precedes the byte. Prediction is purely combinational from hist.
- Reset (async, rst_n=0): state=SEED, hist=0, seed_cnt=0, run_cnt=0, locked=0, err_cnt=0, err_byte=0.
- Cycles with rx_valid=0 change nothing, except that err_clr still acts and err_byte returns to 0.
- SEED state:
  - Shift rx_data into hist; seed_cnt saturates at 4.
  - When seed_cnt reaches 4 (the 4th byte has been shifted in) and hist != 0, go to VERIFY with run_cnt=0.
  - If hist == 0, stay in SEED and re-test on every later byte. An all-zero stream never locks.
- VERIFY state:
  - Compare rx_data with the predicted byte, then shift rx_data (the received bits) into hist.
  - Clean byte: run_cnt++. When run_cnt reaches LOCK_BYTES, go to LOCKED with run_cnt=0.
  - Any mismatch: go to SEED with seed_cnt=0.
  - err_cnt is not touched in VERIFY.
- LOCKED state:
  - Shift the predicted byte, not rx_data, into hist. The local generator free-runs, so each flipped line bit counts exactly once (no error multiplication).
  - popcount(rx_data XOR pred) is added to err_cnt, saturating at 2^ERR_W-1.
  - err_byte=1 on the next cycle if the popcount is nonzero.
  - Errored byte: run_cnt++; clean byte: run_cnt=0.
  - When run_cnt reaches UNLOCK_BYTES, go to SEED with seed_cnt=0. err_cnt is retained.
- Output timing:
  - locked is registered; it rises in the cycle after the edge that accepts the LOCK_BYTES-th clean VERIFY byte.
  - locked falls in the cycle after the edge that accepts the UNLOCK_BYTES-th consecutive errored byte.
  - Total lock latency from reset with a clean stream: 4 + LOCK_BYTES accepted bytes.
- err_clr: takes priority over a same-edge increment, so err_cnt=0 after that edge and that byte's errors are discarded. It has no effect on state or hist.
- Saturation: err_cnt holds at all-ones. Further errors still pulse err_byte and still advance the unlock logic.

Optional Feature:
- Macro: PRBS31_CHK_INVERT_EN.
- Defined:
  - Adds input port rx_invert (1 bit, static config).
  - When rx_invert is high, rx_data is XORed with 0xFF before all processing, so an inverted-polarity stream locks normally.
  - The inversion applies in every state.
- Not defined:
  - No rx_invert port.
  - An inverted stream never passes VERIFY, because the complemented sequence mispredicts every bit.

Test Plan:
- Reset: assert rst_n=0 mid-stream, asynchronously between edges -> state=00, locked=0, err_cnt=0, err_byte=0 immediately, before any clock edge.
- Clean lock: feed a generator stream seeded 0x7FFFFFFF, rx_valid=1 every cycle -> state goes to 01 after byte 4; locked=1 in the cycle after byte 12; err_cnt stays 0 over 1000 bytes.
- Single error: while locked, flip bit 3 of one byte -> err_cnt=1, err_byte pulses once, locked stays 1, no further errors follow.
- Unlock: while locked, XOR 4 consecutive bytes with 0x01 -> err_cnt=4, locked drops after the 4th byte, state=00. A subsequent clean stream relocks after 12 bytes, with err_cnt still 4.
- All-zero input: feed 200 bytes of 0x00 -> state stays 00, locked=0.
- Clear and saturate (ERR_W=4): while locked, inject 20 errored bits in 10 bytes separated by clean bytes -> err_cnt=15. err_clr on the same edge as an errored byte -> err_cnt=0.
